// File: rtl/seed_random_pkg.sv
// Shared constants, FSM state type and card encoding for the card dealer.
package seed_random_pkg;

    localparam int unsigned DECK_SIZE     = 52;
    localparam int unsigned RANKS         = 13;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    // {2'b00, suit, rank}: suit = idx / 13, rank = idx % 13 + 1 (ace = 1)
    function automatic logic [7:0] card_encode(input logic [5:0] idx);
        logic [7:0] code;
        code      = '0;
        code[5:4] = 2'(idx / 6'(RANKS));
        code[3:0] = 4'(idx % 6'(RANKS) + 6'd1);
        return code;
    endfunction

endpackage

// File: rtl/seed_random_card_top_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 to avoid lock-up.
module lfsr16
    import seed_random_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED,
    parameter logic [15:0] TAPS = DEF_LFSR_TAPS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] value_o
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= SEED_EFF;
        end else if (r_lfsr[0]) begin
            r_lfsr <= (r_lfsr >> 1) ^ TAPS;
        end else begin
            r_lfsr <= r_lfsr >> 1;
        end
    end

    assign value_o = r_lfsr;

endmodule

// File: rtl/seed_random_card_top.sv
// Random card dealer: one card per rising edge of request_card_i.
// Define DECK_TRACK_EN to deal without replacement (used mask + linear probe).
module seed_random_card_top
    import seed_random_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED,
    parameter logic [15:0] LFSR_TAPS = DEF_LFSR_TAPS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       request_card_i,
    output logic [7:0] card_to_send_o
);

    logic [15:0] w_lfsr;
    logic        w_rise;
    logic [5:0]  w_start_idx;
    logic        w_unused_lfsr;

    state_t      r_state;
    logic        r_req_q;
    logic [5:0]  r_idx;
    logic [7:0]  r_card;
`ifdef DECK_TRACK_EN
    logic [DECK_SIZE-1:0] r_used;
    logic [5:0]           r_count;
`endif

    lfsr16 #(
        .SEED(LFSR_SEED),
        .TAPS(LFSR_TAPS)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .value_o(w_lfsr)
    );

    assign w_rise        = request_card_i & ~r_req_q;
    assign w_start_idx   = (w_lfsr[5:0] >= 6'(DECK_SIZE)) ? w_lfsr[5:0] - 6'(DECK_SIZE)
                                                          : w_lfsr[5:0];
    assign w_unused_lfsr = ^w_lfsr[15:6];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req_q <= 1'b0;
            r_idx   <= '0;
            r_card  <= '0;
`ifdef DECK_TRACK_EN
            r_used  <= '0;
            r_count <= '0;
`endif
        end else begin
            r_req_q <= request_card_i;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_idx   <= w_start_idx;
                        r_state <= SEARCH;
                    end
                end
                SEARCH: begin
`ifdef DECK_TRACK_EN
                    if (!r_used[r_idx]) begin
                        r_card  <= card_encode(r_idx);
                        r_state <= IDLE;
                        // Dealing the last card reshuffles on the same edge.
                        if (r_count == 6'(DECK_SIZE - 1)) begin
                            r_used  <= '0;
                            r_count <= '0;
                        end else begin
                            r_used[r_idx] <= 1'b1;
                            r_count       <= r_count + 6'd1;
                        end
                    end else begin
                        r_idx <= (r_idx == 6'(DECK_SIZE - 1)) ? 6'd0 : r_idx + 6'd1;
                    end
`else
                    r_card  <= card_encode(r_idx);
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign card_to_send_o = r_card;

endmodule

// File: tb/tb_seed_random_card_top.sv
// Scoreboard bench: a software deck/LFSR model predicts each deal and its edge.
module tb_seed_random_card_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [7:0] card;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    seed_random_card_top #(
        .LFSR_SEED(SEED),
        .LFSR_TAPS(TAPS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .request_card_i(req),
        .card_to_send_o(card)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [7:0]  code;
    } exp_t;

    exp_t        sbq[$];
    int unsigned edge_cnt = 0;
    int          passed = 0;
    int          total  = 0;

    // Reference model state
    logic [15:0] m_lfsr = '0;
    logic        m_req_q = 1'b0;
    int unsigned m_due = 0;
    bit [51:0]   m_used = '0;
    int unsigned m_count = 0;
    bit          m_started = 1'b0;
    logic [7:0]  m_out = '0;

    bit          rec = 1'b0;
    bit          seen[256];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    function automatic logic [7:0] idx_to_code(input int unsigned idx);
        return 8'((idx / 13) * 16 + (idx % 13) + 1);
    endfunction

    function automatic logic fmt_ok(input logic [7:0] c);
        return (c[7:6] == 2'b00) && (c[3:0] >= 4'd1) && (c[3:0] <= 4'd13);
    endfunction

    // Model: steps the LFSR arithmetically and deals from a software deck.
    always @(posedge clk) begin
        int unsigned idx;
        int unsigned probes;
        edge_cnt++;
        if (rst) begin
            sbq.delete();
            sbq.push_back('{edge_cnt, 8'h00});
            m_lfsr    = SEED;
            m_req_q   = 1'b0;
            m_due     = 0;
            m_used    = '0;
            m_count   = 0;
            m_started = 1'b1;
        end else begin
            if (req && !m_req_q && edge_cnt > m_due) begin
                idx    = int'(m_lfsr[5:0]);
                if (idx >= 52) idx -= 52;
                probes = 0;
`ifdef DECK_TRACK_EN
                while (m_used[idx]) begin
                    idx = (idx + 1) % 52;
                    probes++;
                end
                m_used[idx] = 1'b1;
                m_count++;
                if (m_count == 52) begin
                    m_used  = '0;
                    m_count = 0;
                end
`endif
                m_due = edge_cnt + 1 + probes;
                sbq.push_back('{m_due, idx_to_code(idx)});
            end
            m_req_q = req;
            m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
        end
    end

    // Monitor: compares on the due edge, otherwise the held value must not move.
    always @(negedge clk) begin
        exp_t e;
        if (m_started) begin
            if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
                e     = sbq.pop_front();
                m_out = e.code;
                chk("deal", {8'h00, card}, {8'h00, m_out});
                if (m_out != 8'h00) begin
                    chk("format", {15'h0, fmt_ok(card)}, 16'h0001);
                    if (rec) seen[card] = 1'b1;
                end
            end else begin
                chk("hold", {8'h00, card}, {8'h00, m_out});
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        req = 1'b0;
        @(negedge clk) rst = 1'b0;
        chk("lfsr_seed", dut.w_lfsr, SEED);
    endtask

    task automatic pulse(input int hi, input int lo);
        req = 1'b1;
        wait_neg(hi);
        req = 1'b0;
        wait_neg(lo);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        do_reset();

        // Single deal 5 cycles after reset, then output held
        wait_neg(5);
        pulse(1, 20);

        // Held request deals exactly once
        req = 1'b1;
        wait_neg(100);
        req = 1'b0;
        wait_neg(60);

        // Second rise shortly after the first (ignored if still searching)
        pulse(1, 1);
        pulse(1, 60);

        // Reset while the deal is pending
        @(negedge clk) req = 1'b1;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin
            rst = 1'b0;
            req = 1'b0;
        end
        chk("lfsr_after_abort", dut.w_lfsr, SEED);
        wait_neg(10);

`ifdef DECK_TRACK_EN
        do_reset();
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        rec = 1'b1;
        for (int p = 0; p < 52; p++) pulse(2, 58);
        rec = 1'b0;
        n = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) n++;
        chk("distinct_52", 16'(n), 16'd52);
        pulse(2, 58);
`endif

        // Randomized requests with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) req = ~req;
        end
        rst = 1'b0;
        req = 1'b0;

        n = 0;
        while (sbq.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 16'(sbq.size()), 16'd0);
        wait_neg(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
